rom_string_streamer: RTL and testbench



---
 rtl/rom_string_streamer_if.sv | 24 ++
 rtl/rom_string_streamer.sv | 115 +++++++++++
 tb/tb_rom_string_streamer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_string_streamer_if.sv
// Valid/ready character stream between the ROM streamer and its consumer.
// Ports: out_data, out_valid, out_last from master; out_ready from slave.
interface rom_string_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_string_streamer.sv
// Streams MSG_LEN characters from the character ROM, one per handshake.
// Ports: clk, rst_n, start, addr/romout (ROM side), out (stream), busy, done.
module rom_string_streamer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int MSG_LEN    = 16,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     romout,
    rom_string_streamer_if.master out,
    output logic                  busy,
    output logic                  done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
    localparam logic ONE_CHAR = (MSG_LEN == 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic              last_q, last_n;
    logic              busy_n, done_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              hs;

    assign hs            = valid_q && out.out_ready;
    assign out.out_data  = data_q;
    assign out.out_valid = valid_q;
    assign out.out_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= START;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            busy    <= busy_n;
            done    <= done_n;
            count   <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        data_n  = data_q;
        valid_n = valid_q;
        last_n  = last_q;
        busy_n  = busy;
        done_n  = 1'b0;
        count_n = count;
        unique case (state)
            IDLE: begin
                addr_n = START;
                if (start) begin
                    state_n = FETCH;
                    busy_n  = 1'b1;
                    count_n = '0;
                end
            end
            FETCH: begin
                data_n  = romout;
                valid_n = 1'b1;
                last_n  = ONE_CHAR;
                addr_n  = addr + 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (last_q) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        // addr already points one past the shown character
                        data_n  = romout;
                        addr_n  = addr + 1'b1;
                        count_n = count + 1'b1;
                        last_n  = ((count + 1'b1) == LAST_IDX);
                    end
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                addr_n  = START;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rom_string_streamer.sv
// Randomized bench with an output-level model for two streamer configurations.
// Instance a: defaults; instance b: START_ADDR=14, MSG_LEN=4 (address wrap).
module tb_rom_string_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [3:0] addr_a, addr_b;
    logic [7:0] rom_a, rom_b;
    logic busy_a, busy_b, done_a, done_b;
    logic rdy [2] = '{1'b1, 1'b1};
    int mode = 0;

    always #5 clk = ~clk;

    logic [7:0] rom [16] = '{8'h53, 8'h50, 8'h41, 8'h54, 8'h41, 8'h52,
        8'h55, 8'h49, 8'h4F, 8'h4E, 8'h45, 8'h53, 8'h43, 8'h55, 8'h42,
        8'h38};
    logic [7:0] exp_full [16] = '{8'h53, 8'h50, 8'h41, 8'h54, 8'h41,
        8'h52, 8'h55, 8'h49, 8'h4F, 8'h4E, 8'h45, 8'h53, 8'h43, 8'h55,
        8'h42, 8'h38};
    logic [7:0] exp_wrap [4] = '{8'h42, 8'h38, 8'h53, 8'h50};

    assign rom_a = rom[addr_a];
    assign rom_b = rom[addr_b];

    rom_string_streamer_if if_a ();
    rom_string_streamer_if if_b ();
    assign if_a.out_ready = rdy[0];
    assign if_b.out_ready = rdy[1];

    rom_string_streamer dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .addr(addr_a),
        .romout(rom_a), .out(if_a.master), .busy(busy_a), .done(done_a)
    );

    rom_string_streamer #(
        .START_ADDR(14), .MSG_LEN(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .addr(addr_b),
        .romout(rom_b), .out(if_b.master), .busy(busy_b), .done(done_b)
    );

    logic [7:0] od [2];
    logic [3:0] oa [2];
    logic ov [2], ol [2], ob [2], odn [2], st [2];
    assign od[0] = if_a.out_data;  assign od[1] = if_b.out_data;
    assign ov[0] = if_a.out_valid; assign ov[1] = if_b.out_valid;
    assign ol[0] = if_a.out_last;  assign ol[1] = if_b.out_last;
    assign oa[0] = addr_a;  assign oa[1] = addr_b;
    assign ob[0] = busy_a;  assign ob[1] = busy_b;
    assign odn[0] = done_a; assign odn[1] = done_b;
    assign st[0] = start_a; assign st[1] = start_b;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Output-level model: message progress tracked by character index.
    int SA [2] = '{0, 14};
    int LEN [2] = '{16, 4};
    bit busy_m [2], fetch_m [2], valid_m [2], done_m [2], stalled [2];
    int idx [2], nhs [2], ndone [2], tacc [2], tdone [2];
    logic [7:0] pdata [2];
    logic [7:0] got_a [$];
    logic [7:0] got_b [$];
    int cyc = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("rst_valid", ov[d], 0);
                chk("rst_busy", ob[d], 0);
                chk("rst_done", odn[d], 0);
                chk("rst_last", ol[d], 0);
                chk("rst_data", od[d], 0);
                chk("rst_addr", oa[d], SA[d]);
                busy_m[d] = 0; fetch_m[d] = 0; valid_m[d] = 0;
                done_m[d] = 0; idx[d] = 0; stalled[d] = 0;
            end else begin
                bit nb, nv, nd;
                chk("valid", ov[d], valid_m[d]);
                chk("busy", ob[d], busy_m[d]);
                chk("done", odn[d], done_m[d]);
                if (valid_m[d]) begin
                    chk("data", od[d], rom[(SA[d] + idx[d]) % 16]);
                    chk("last", ol[d], idx[d] == LEN[d] - 1);
                    chk("addr_send", oa[d], (SA[d] + idx[d] + 1) % 16);
                end else if (done_m[d]) begin
                    chk("addr_done", oa[d], (SA[d] + LEN[d]) % 16);
                end else begin
                    chk("addr_idle", oa[d], SA[d]);
                end
                if (stalled[d]) chk("stall_hold", od[d], pdata[d]);
                stalled[d] = ov[d] && !rdy[d];
                pdata[d] = od[d];
                if (odn[d]) begin
                    ndone[d]++;
                    tdone[d] = cyc;
                end
                nb = busy_m[d]; nv = valid_m[d]; nd = 0;
                if (done_m[d]) nb = 0;
                if (!busy_m[d] && st[d]) begin
                    nb = 1;
                    tacc[d] = cyc;
                end
                if (fetch_m[d]) begin
                    nv = 1;
                    idx[d] = 0;
                end
                fetch_m[d] = !busy_m[d] && st[d];
                if (valid_m[d] && rdy[d]) begin
                    nhs[d]++;
                    if (d == 0) got_a.push_back(od[d]);
                    else got_b.push_back(od[d]);
                    if (idx[d] == LEN[d] - 1) begin
                        nv = 0;
                        nd = 1;
                    end else begin
                        idx[d]++;
                    end
                end
                busy_m[d] = nb; valid_m[d] = nv; done_m[d] = nd;
            end
        end
        cyc++;
    end

    bit [5:0] pat = 6'b101001;
    int pk = 0;
    always @(posedge clk) begin
        #1;
        case (mode)
            0: begin rdy[0] = 1'b1; rdy[1] = 1'b1; end
            1: begin
                rdy[0] = pat[pk % 6];
                rdy[1] = pat[pk % 6];
                pk++;
            end
            default: begin
                rdy[0] = 1'($urandom_range(0, 1));
                rdy[1] = 1'($urandom_range(0, 1));
            end
        endcase
    end

    task automatic pulse(int d);
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle(int d, int budget);
        int n = 0;
        while ((busy_m[d] || st[d]) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_timeout", n >= budget, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, nd0, n;
        start_a = 1'b1; start_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_busy", busy_a, 0);
        chk("rst_hold_addr", addr_a, 0);
        start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", busy_a, 0);

        got_a.delete();
        pulse(0);
        wait_idle(0, 40);
        chk("full_len", got_a.size(), 16);
        for (int i = 0; i < 16 && i < got_a.size(); i++)
            chk("full_char", got_a[i], exp_full[i]);
        chk("full_timing", tdone[0] - tacc[0], 18);
        chk("full_ndone", ndone[0], 1);

        mode = 1;
        got_a.delete();
        pulse(0);
        wait_idle(0, 120);
        chk("bp_len", got_a.size(), 16);
        for (int i = 0; i < 16 && i < got_a.size(); i++)
            chk("bp_char", got_a[i], exp_full[i]);

        mode = 0;
        got_b.delete();
        pulse(1);
        wait_idle(1, 20);
        chk("wrap_len", got_b.size(), 4);
        for (int i = 0; i < 4 && i < got_b.size(); i++)
            chk("wrap_char", got_b[i], exp_wrap[i]);
        chk("wrap_timing", tdone[1] - tacc[1], 6);

        base = nhs[0]; nd0 = ndone[0];
        pulse(0);
        repeat (5) @(posedge clk);
        #1;
        pulse(0);
        n = 0;
        while (!done_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done_a, 1);
        pulse(0);
        wait_idle(0, 40);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_hs", nhs[0] - base, 16);
        chk("ign_ndone", ndone[0] - nd0, 1);
        chk("ign_idle", busy_a, 0);

        base = nhs[0]; nd0 = ndone[0];
        pulse(0);
        n = 0;
        while (nhs[0] < base + 5 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", if_a.out_valid, 0);
        chk("async_busy", busy_a, 0);
        chk("async_addr", addr_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_nodone", ndone[0] - nd0, 0);
        got_a.delete();
        pulse(0);
        wait_idle(0, 40);
        chk("restart_len", got_a.size(), 16);
        if (got_a.size() > 0) chk("restart_first", got_a[0], 8'h53);

        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            start_a = ($urandom_range(0, 9) == 0);
            start_b = ($urandom_range(0, 3) == 0);
            if (i >= 600 && i < 700) start_a = 1'b1;
            @(posedge clk); #1;
        end
        start_a = 1'b0; start_b = 1'b0;
        wait_idle(0, 200);
        wait_idle(1, 200);
        chk("rand_done_a", ndone[0] > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
